// File: rtl/rmt_recovery_sequencer_if.sv
// Bundle between the recovery sequencer, its requester, the retirement RMT read
// ports and the speculative RMT / WAT write ports.
interface rmt_recovery_sequencer_if #(
  parameter int LREG_NUM_BIT_WIDTH = 6,
  parameter int PREG_NUM_BIT_WIDTH = 7,
  parameter int IQ_INDEX_BIT_WIDTH = 4,
  parameter int COPY_WIDTH         = 2
);
  logic                                       recoveryReq;
  logic                                       busy;
  logic                                       renameStall;
  logic                                       done;
  logic [COPY_WIDTH*LREG_NUM_BIT_WIDTH-1:0]   retRMT_ReadReg_LogRegNum;
  logic [COPY_WIDTH*PREG_NUM_BIT_WIDTH-1:0]   retRMT_ReadReg_PhyRegNum;
  logic [COPY_WIDTH-1:0]                      rmtWriteReg;
  logic [COPY_WIDTH*LREG_NUM_BIT_WIDTH-1:0]   rmtWriteReg_LogRegNum;
  logic [COPY_WIDTH*PREG_NUM_BIT_WIDTH-1:0]   rmtWriteReg_PhyRegNum;
  logic [COPY_WIDTH-1:0]                      watWriteReg;
  logic [COPY_WIDTH*LREG_NUM_BIT_WIDTH-1:0]   watWriteLogRegNum;
  logic [COPY_WIDTH*IQ_INDEX_BIT_WIDTH-1:0]   watWriteIssueQueuePtr;

  // The surrounding pipeline (requester plus tables) is the master side.
  modport master (
    output recoveryReq, retRMT_ReadReg_PhyRegNum,
    input  busy, renameStall, done, retRMT_ReadReg_LogRegNum,
           rmtWriteReg, rmtWriteReg_LogRegNum, rmtWriteReg_PhyRegNum,
           watWriteReg, watWriteLogRegNum, watWriteIssueQueuePtr
  );

  modport slave (
    input  recoveryReq, retRMT_ReadReg_PhyRegNum,
    output busy, renameStall, done, retRMT_ReadReg_LogRegNum,
           rmtWriteReg, rmtWriteReg_LogRegNum, rmtWriteReg_PhyRegNum,
           watWriteReg, watWriteLogRegNum, watWriteIssueQueuePtr
  );
endinterface

// File: rtl/rmt_recovery_sequencer.sv
// Copies the retirement RMT into the speculative RMT after a flush, COPY_WIDTH
// entries per cycle, clearing the matching WAT entries in the same write.
module rmt_recovery_sequencer #(
  parameter int LREG_NUM           = 64,
  parameter int LREG_NUM_BIT_WIDTH = 6,
  parameter int PREG_NUM_BIT_WIDTH = 7,
  parameter int IQ_INDEX_BIT_WIDTH = 4,
  parameter int COPY_WIDTH         = 2
) (
  input logic                   clk,
  input logic                   rst,
  rmt_recovery_sequencer_if.slave bus
);
  localparam int LW    = LREG_NUM_BIT_WIDTH;
  localparam int PW    = PREG_NUM_BIT_WIDTH;
  localparam int PTR_W = LREG_NUM_BIT_WIDTH + 1;
  localparam logic [PTR_W-1:0] STEP     = PTR_W'(COPY_WIDTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LREG_NUM - COPY_WIDTH);

  typedef enum logic [1:0] {IDLE, COPY, DRAIN} state_t;

  state_t                       state, state_next;
  logic [PTR_W-1:0]             ptr, ptr_next;
  logic                         busy, done;
  logic [COPY_WIDTH*LW-1:0]     read_addr;
  logic                         wr_valid;
  logic [COPY_WIDTH*LW-1:0]     wr_addr;
  logic [COPY_WIDTH*PW-1:0]     wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // A request in any state (re)starts the walk from entry 0.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (bus.recoveryReq) begin
          state_next = COPY;
          ptr_next   = '0;
        end
      end
      COPY: begin
        if (bus.recoveryReq) begin
          ptr_next = '0;
        end else begin
          ptr_next = ptr + STEP;
          if (ptr == LAST_PTR) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.recoveryReq) begin
          state_next = COPY;
          ptr_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DRAIN);
    read_addr = '0;
    if (state == COPY) begin
      for (int i = 0; i < COPY_WIDTH; i++) begin
        read_addr[i*LW +: LW] = LW'(ptr + PTR_W'(i));
      end
    end
  end

  // Write stage: holds one cycle of read results; zeroed when nothing to write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (state == COPY) begin
      wr_valid <= 1'b1;
      wr_addr  <= read_addr;
      wr_data  <= bus.retRMT_ReadReg_PhyRegNum;
    end else begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end
  end

  assign bus.busy                     = busy;
  assign bus.done                     = done;
  assign bus.renameStall              = busy | bus.recoveryReq;
  assign bus.retRMT_ReadReg_LogRegNum = read_addr;
  assign bus.rmtWriteReg              = {COPY_WIDTH{wr_valid}};
  assign bus.rmtWriteReg_LogRegNum    = wr_addr;
  assign bus.rmtWriteReg_PhyRegNum    = wr_data;
  assign bus.watWriteReg              = {COPY_WIDTH{wr_valid}};
  assign bus.watWriteLogRegNum        = wr_addr;
  assign bus.watWriteIssueQueuePtr    = '0;
endmodule

// File: tb/tb_rmt_recovery_sequencer.sv
// Directed bench for rmt_recovery_sequencer: reset, full walk, restart,
// back-to-back requests, reset mid-walk and rename stall timing.
module tb_rmt_recovery_sequencer;
  logic clk;
  logic rst;
  int   n_compared;
  int   n_failed;
  int   rmt_writes;
  int   wat_writes;
  int   cyc;

  rmt_recovery_sequencer_if #(
    .LREG_NUM_BIT_WIDTH(6), .PREG_NUM_BIT_WIDTH(7),
    .IQ_INDEX_BIT_WIDTH(4), .COPY_WIDTH(2)
  ) bus ();

  rmt_recovery_sequencer #(
    .LREG_NUM(64), .LREG_NUM_BIT_WIDTH(6), .PREG_NUM_BIT_WIDTH(7),
    .IQ_INDEX_BIT_WIDTH(4), .COPY_WIDTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Retirement RMT model: logical register n maps to physical register n+64.
  always_comb begin
    bus.retRMT_ReadReg_PhyRegNum = '0;
    for (int i = 0; i < 2; i++) begin
      bus.retRMT_ReadReg_PhyRegNum[i*7 +: 7] = {1'b1, bus.retRMT_ReadReg_LogRegNum[i*6 +: 6]};
    end
  end

  task automatic applyStimulus(input logic req_val, input logic rst_val);
    @(posedge clk);
    #2;
    cyc++;
    bus.recoveryReq = req_val;
    rst = rst_val;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_failed++;
      $error("[TB] FAIL %s (t=%0d): observed %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  // Checks one cycle of an undisturbed walk, r cycles after the request cycle.
  task automatic checkWalk(input int r, input logic req_now);
    logic        exp_busy, exp_wr;
    int          lane0, w;
    logic [31:0] exp_read, exp_waddr, exp_wdata;
    exp_busy  = (r >= 1 && r <= 33);
    exp_wr    = (r >= 2 && r <= 33);
    lane0     = 2 * (r - 1);
    w         = 2 * (r - 2);
    exp_read  = (r >= 1 && r <= 32) ? 32'(((lane0 + 1) << 6) | lane0) : 32'd0;
    exp_waddr = exp_wr ? 32'(((w + 1) << 6) | w) : 32'd0;
    exp_wdata = exp_wr ? 32'(((w + 65) << 7) | (w + 64)) : 32'd0;
    checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
    checkOutput("done", 32'(bus.done), 32'(r == 33));
    checkOutput("renameStall", 32'(bus.renameStall), 32'(exp_busy | req_now));
    checkOutput("read_addr", 32'(bus.retRMT_ReadReg_LogRegNum), exp_read);
    checkOutput("rmtWriteReg", 32'(bus.rmtWriteReg), exp_wr ? 32'd3 : 32'd0);
    checkOutput("watWriteReg", 32'(bus.watWriteReg), exp_wr ? 32'd3 : 32'd0);
    checkOutput("rmt_addr", 32'(bus.rmtWriteReg_LogRegNum), exp_waddr);
    checkOutput("rmt_data", 32'(bus.rmtWriteReg_PhyRegNum), exp_wdata);
    checkOutput("wat_addr", 32'(bus.watWriteLogRegNum), exp_waddr);
    checkOutput("wat_iq_ptr", 32'(bus.watWriteIssueQueuePtr), 32'd0);
    rmt_writes += $countones(bus.rmtWriteReg);
    wat_writes += $countones(bus.watWriteReg);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_rmtWriteReg"}, 32'(bus.rmtWriteReg), 32'd0);
    checkOutput({tag, "_watWriteReg"}, 32'(bus.watWriteReg), 32'd0);
    checkOutput({tag, "_renameStall"}, 32'(bus.renameStall), 32'd0);
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    cyc        = 0;
    rst        = 1'b1;
    bus.recoveryReq = 1'b0;

    // Reset, then five idle cycles.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkIdle("reset");
    checkOutput("reset_read_addr", 32'(bus.retRMT_ReadReg_LogRegNum), 32'd0);
    checkOutput("reset_rmt_data", 32'(bus.rmtWriteReg_PhyRegNum), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkIdle("idle");
    end

    // Full walk; stall is asserted in the request cycle before busy.
    $display("[TB] full walk");
    rmt_writes = 0;
    wat_writes = 0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("req_cycle_stall", 32'(bus.renameStall), 32'd1);
    checkOutput("req_cycle_busy", 32'(bus.busy), 32'd0);
    for (int r = 1; r <= 34; r++) begin
      applyStimulus(1'b0, 1'b0);
      checkWalk(r, 1'b0);
    end
    checkOutput("walk_rmt_writes", 32'(rmt_writes), 32'd64);
    checkOutput("walk_wat_writes", 32'(wat_writes), 32'd64);

    // Restart at cycle 10: the cycle-10 read {18,19} still writes in cycle 11.
    $display("[TB] restart");
    applyStimulus(1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(c == 10, 1'b0);
      checkWalk(c, c == 10);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("restart_read_addr", 32'(bus.retRMT_ReadReg_LogRegNum), 32'h040);
    checkOutput("restart_busy", 32'(bus.busy), 32'd1);
    checkOutput("restart_done", 32'(bus.done), 32'd0);
    checkOutput("restart_old_wr", 32'(bus.rmtWriteReg), 32'd3);
    checkOutput("restart_old_addr", 32'(bus.rmtWriteReg_LogRegNum), 32'((19 << 6) | 18));
    checkOutput("restart_old_data", 32'(bus.rmtWriteReg_PhyRegNum), 32'((83 << 7) | 82));
    for (int c = 12; c <= 44; c++) begin
      applyStimulus(1'b0, 1'b0);
      checkWalk(c - 10, 1'b0);
    end

    // Back-to-back: a request in the done cycle starts a new walk directly.
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      applyStimulus(c == 33, 1'b0);
      checkWalk(c, c == 33);
    end
    for (int r = 1; r <= 34; r++) begin
      applyStimulus(1'b0, 1'b0);
      checkWalk(r, 1'b0);
    end

    // Reset in cycle 15 of a walk, then a complete fresh walk.
    $display("[TB] reset mid-walk");
    applyStimulus(1'b1, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(1'b0, 1'b0);
      checkWalk(c, 1'b0);
    end
    applyStimulus(1'b0, 1'b1);
    checkIdle("midreset");
    checkOutput("midreset_read_addr", 32'(bus.retRMT_ReadReg_LogRegNum), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkIdle("post_reset");
    end
    rmt_writes = 0;
    wat_writes = 0;
    applyStimulus(1'b1, 1'b0);
    for (int r = 1; r <= 34; r++) begin
      applyStimulus(1'b0, 1'b0);
      checkWalk(r, 1'b0);
    end
    checkOutput("rewalk_rmt_writes", 32'(rmt_writes), 32'd64);
    checkOutput("rewalk_wat_writes", 32'(wat_writes), 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end
endmodule
